// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with req/addr_ok/data_ok SRAM port and one-entry buffer
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC00000,
    parameter logic [4:0]  EXC_ADEL  = 5'h04
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allowin_in,
    output logic        if_valid_out,
    output logic [31:0] if_PC_in_flight_out,
    input  logic [31:0] id_nextPC_in,
    output logic [31:0] if_NPC_fast_out,
    input  logic        wb_ClrStpJmp_in,
    input  logic [31:0] wb_cp0_res_in,
    output logic [31:0] if_PC_out,
    output logic [31:0] if_NPC_out,
    output logic [31:0] if_NNPC_out,
    output logic [31:0] if_Instruct_out,
    output logic        if_exception_out,
    output logic [4:0]  if_ExcCode_out,
    output logic [31:0] if_error_VAddr_out,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_HOLD   = 2'd2,
        S_CANCEL = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic [31:0] r_nnpc;
    logic [31:0] r_instr;
    logic        r_exc;
    logic [4:0]  r_exccode;
    logic [31:0] r_vaddr;

    logic        w_misaligned;

    assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);

    // Request only from REQ with an aligned PC; held low while reset is asserted
    assign inst_req            = (r_state == S_REQ) && !w_misaligned && !rst;
    assign inst_addr           = r_fetch_pc;
    assign if_PC_in_flight_out = r_fetch_pc;
    assign if_NPC_fast_out     = r_fetch_pc + 32'd4;

    assign if_valid_out       = r_valid;
    assign if_PC_out          = r_pc;
    assign if_NPC_out         = r_npc;
    assign if_NNPC_out        = r_nnpc;
    assign if_Instruct_out    = r_instr;
    assign if_exception_out   = r_exc;
    assign if_ExcCode_out     = r_exccode;
    assign if_error_VAddr_out = r_vaddr;

    // Fetch FSM: redirect wins over every other event; buffer is cleared on redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_PC;
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_npc      <= 32'd0;
            r_nnpc     <= 32'd0;
            r_instr    <= 32'd0;
            r_exc      <= 1'b0;
            r_exccode  <= 5'd0;
            r_vaddr    <= 32'd0;
        end else if (wb_ClrStpJmp_in) begin
            r_fetch_pc <= wb_cp0_res_in;
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_npc      <= 32'd0;
            r_nnpc     <= 32'd0;
            r_instr    <= 32'd0;
            r_exc      <= 1'b0;
            r_exccode  <= 5'd0;
            r_vaddr    <= 32'd0;
            case (r_state)
                S_REQ:    r_state <= (inst_req && inst_addr_ok) ? S_CANCEL : S_REQ;
                S_WAIT:   r_state <= inst_data_ok ? S_REQ : S_CANCEL;
                // A response landing now belongs to the old request, so nothing is left outstanding
                S_CANCEL: r_state <= inst_data_ok ? S_REQ : S_CANCEL;
                default:  r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_misaligned) begin
                        r_state   <= S_HOLD;
                        r_valid   <= 1'b1;
                        r_pc      <= r_fetch_pc;
                        r_npc     <= r_fetch_pc + 32'd4;
                        r_nnpc    <= r_fetch_pc + 32'd8;
                        r_instr   <= 32'd0;
                        r_exc     <= 1'b1;
                        r_exccode <= EXC_ADEL;
                        r_vaddr   <= r_fetch_pc;
                    end else if (inst_addr_ok) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        r_state   <= S_HOLD;
                        r_valid   <= 1'b1;
                        r_pc      <= r_fetch_pc;
                        r_npc     <= r_fetch_pc + 32'd4;
                        r_nnpc    <= r_fetch_pc + 32'd8;
                        r_instr   <= inst_rdata;
                        r_exc     <= 1'b0;
                        r_exccode <= 5'd0;
                        r_vaddr   <= 32'd0;
                    end
                end
                S_HOLD: begin
                    if (id_allowin_in) begin
                        r_state    <= S_REQ;
                        r_valid    <= 1'b0;
                        r_fetch_pc <= id_nextPC_in;
                    end
                end
                default: begin
                    if (inst_data_ok) begin
                        r_state <= S_REQ;
                    end
                end
            endcase
        end
    end

endmodule
